// File: rtl/alu_iter_pkg.sv
// alu_iter_pkg: opcodes and FSM states for alu_iter; the MUL state exists only when ALU_ITER_MUL_EN is defined.
package alu_iter_pkg;
    localparam logic [3:0] OP_PASS_A = 4'h0;
    localparam logic [3:0] OP_PASS_B = 4'h1;
    localparam logic [3:0] OP_NOT_A  = 4'h2;
    localparam logic [3:0] OP_NOT_B  = 4'h3;
    localparam logic [3:0] OP_ADD    = 4'h4;
    localparam logic [3:0] OP_ADC    = 4'h5;
    localparam logic [3:0] OP_OR     = 4'h6;
    localparam logic [3:0] OP_AND    = 4'h7;
    localparam logic [3:0] OP_ZERO   = 4'h8;
    localparam logic [3:0] OP_ONE    = 4'h9;
    localparam logic [3:0] OP_ONES   = 4'hA;
    localparam logic [3:0] OP_CLC    = 4'hB;
    localparam logic [3:0] OP_STC    = 4'hC;
    localparam logic [3:0] OP_SUB    = 4'hD;
    localparam logic [3:0] OP_SHL    = 4'hE;
    localparam logic [3:0] OP_MUL    = 4'hF;
`ifdef ALU_ITER_MUL_EN
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_MUL} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_SHIFT} state_t;
`endif
endpackage

// File: rtl/alu_iter_mul.sv
// alu_iter_mul: shift-add multiplier, one partial product per clock; built only with ALU_ITER_MUL_EN.
`ifdef ALU_ITER_MUL_EN
module alu_iter_mul #(
    parameter int WIDTH = 16,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic                 System_Clk,
    input  logic                 Reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   prod
);
    logic [WIDTH-1:0] mcand, hi, lo;
    logic [WIDTH:0]   hi_sum;
    logic [CNT_W-1:0] cnt;
    logic             busy;

    // prod is the next {hi,lo}; done flags the step that produces the final product
    assign hi_sum = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
    assign prod   = {hi_sum, lo[WIDTH-1:1]};
    assign done   = busy && cnt == CNT_W'(WIDTH - 1);

    always_ff @(posedge System_Clk) begin
        if (Reset) begin
            mcand <= '0;
            hi    <= '0;
            lo    <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
        end else if (start) begin
            mcand <= a;
            lo    <= b;
            hi    <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
        end else if (busy) begin
            {hi, lo} <= prod;
            cnt      <= cnt + CNT_W'(1);
            if (done) busy <= 1'b0;
        end
    end
endmodule
`endif

// File: rtl/alu_iter.sv
// alu_iter: handshaked ALU with registered flags, iterative SHL and, under ALU_ITER_MUL_EN,
// a shift-add multiply on code 1111 (otherwise 1111 is a single-cycle add).
module alu_iter
    import alu_iter_pkg::*;
#(
    parameter int WIDTH = 16,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             System_Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [3:0]       ALU_Sel,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cy_In,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] ALU_Out,
    output logic [WIDTH-1:0] ALU_Out_Hi,
    output logic             CY_Out,
    output logic             Z_Out,
    output logic             N_Out,
    output logic             V_Out
);
    state_t           state;
    logic [3:0]       op;
    logic [WIDTH-1:0] b_op, sh, res, fin_lo, fin_hi;
    logic [WIDTH:0]   sum;
    logic [CNT_W-1:0] cnt, k;
    logic             go, sub, ovf, cy_n, v_n, fin, fin_cy, fin_v;

`ifdef ALU_ITER_MUL_EN
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;
    assign op = ALU_Sel;
    alu_iter_mul #(.WIDTH(WIDTH)) u_mul (
        .System_Clk(System_Clk),
        .Reset(Reset),
        .start(go && op == OP_MUL),
        .a(A),
        .b(B),
        .done(mul_done),
        .prod(mul_prod)
    );
`else
    assign op = (ALU_Sel == OP_MUL) ? OP_ADD : ALU_Sel;
`endif

    // one adder serves ADD/ADC/SUB; SUB is A + ~B + 1 with carry inverted into a borrow
    assign go   = state == S_IDLE && Start;
    assign k    = B[CNT_W-1:0];
    assign sub  = op == OP_SUB;
    assign b_op = sub ? ~B : B;
    assign sum  = {1'b0, A} + {1'b0, b_op} + (WIDTH+1)'(sub | (op == OP_ADC & Cy_In));
    assign ovf  = (A[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);

    always_comb begin
        res  = '0;
        cy_n = 1'b0;
        v_n  = 1'b0;
        case (op)
            OP_PASS_A: res = A;
            OP_PASS_B: res = B;
            OP_NOT_A:  res = ~A;
            OP_NOT_B:  res = ~B;
            OP_ADD, OP_ADC, OP_SUB: begin
                res  = sum[WIDTH-1:0];
                cy_n = sum[WIDTH] ^ sub;
                v_n  = ovf;
            end
            OP_OR:   res = A | B;
            OP_AND:  res = A & B;
            OP_ONE:  begin res = WIDTH'(1); cy_n = CY_Out; end
            OP_ONES: begin res = '1; cy_n = CY_Out; end
            OP_CLC:  res = ALU_Out;
            OP_STC:  begin res = ALU_Out; cy_n = 1'b1; end
            OP_SHL:  begin res = A; cy_n = CY_Out; end
            default: ;
        endcase
    end

    always_comb begin
        fin    = 1'b0;
        fin_lo = res;
        fin_hi = '0;
        fin_cy = cy_n;
        fin_v  = v_n;
        if (go && !(op == OP_SHL && k != '0) && op != OP_MUL) begin
            fin = 1'b1;
        end else if (state == S_SHIFT && cnt == CNT_W'(1)) begin
            fin    = 1'b1;
            fin_lo = sh << 1;
            fin_cy = sh[WIDTH-1];
            fin_v  = 1'b0;
`ifdef ALU_ITER_MUL_EN
        end else if (state == S_MUL && mul_done) begin
            fin    = 1'b1;
            fin_lo = mul_prod[WIDTH-1:0];
            fin_hi = mul_prod[2*WIDTH-1:WIDTH];
            fin_cy = |mul_prod[2*WIDTH-1:WIDTH];
            fin_v  = 1'b0;
`endif
        end
    end

    always_ff @(posedge System_Clk) begin
        if (Reset) begin
            state      <= S_IDLE;
            sh         <= '0;
            cnt        <= '0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
            ALU_Out    <= '0;
            ALU_Out_Hi <= '0;
            CY_Out     <= 1'b0;
            Z_Out      <= 1'b0;
            N_Out      <= 1'b0;
            V_Out      <= 1'b0;
        end else begin
            Done <= fin;
            if (fin) begin
                ALU_Out    <= fin_lo;
                ALU_Out_Hi <= fin_hi;
                CY_Out     <= fin_cy;
                Z_Out      <= fin_lo == '0;
                N_Out      <= fin_lo[WIDTH-1];
                V_Out      <= fin_v;
            end
            if (go && op == OP_SHL && k != '0) begin
                state <= S_SHIFT;
                Busy  <= 1'b1;
                sh    <= A;
                cnt   <= k;
`ifdef ALU_ITER_MUL_EN
            end else if (go && op == OP_MUL) begin
                state <= S_MUL;
                Busy  <= 1'b1;
`endif
            end else if (state == S_SHIFT) begin
                sh  <= sh << 1;
                cnt <= cnt - CNT_W'(1);
            end
            if (fin && state != S_IDLE) begin
                state <= S_IDLE;
                Busy  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_iter.sv
// tb_alu_iter: directed plus random operations checked against an arithmetic reference model.
module tb_alu_iter;
    localparam int W = 16;

    logic         System_Clk = 1'b0, Reset = 1'b1, Start = 1'b0, Cy_In = 1'b0;
    logic [3:0]   ALU_Sel = '0;
    logic [W-1:0] A = '0, B = '0;
    logic         Busy, Done, CY_Out, Z_Out, N_Out, V_Out;
    logic [W-1:0] ALU_Out, ALU_Out_Hi;
    int           passes = 0, total = 0;
    logic [W-1:0] m_out = '0;
    logic         m_cy = 1'b0;

    always #5 System_Clk = ~System_Clk;

    alu_iter #(.WIDTH(W)) dut (
        .System_Clk(System_Clk), .Reset(Reset), .Start(Start), .ALU_Sel(ALU_Sel),
        .A(A), .B(B), .Cy_In(Cy_In), .Busy(Busy), .Done(Done),
        .ALU_Out(ALU_Out), .ALU_Out_Hi(ALU_Out_Hi),
        .CY_Out(CY_Out), .Z_Out(Z_Out), .N_Out(N_Out), .V_Out(V_Out)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    // expected result from plain integer arithmetic; lat = edges after the Start edge until Done
    task automatic model(input logic [3:0] sel, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, output logic [W-1:0] o, output logic [W-1:0] hi,
                         output logic cy, output logic v, output int lat);
        int sa, sb, c, u, r, k;
        logic [31:0] x;
        sa = $signed(a);
        sb = $signed(b);
        o = '0; hi = '0; cy = 1'b0; v = 1'b0; lat = 0; k = int'(b[3:0]);
`ifndef ALU_ITER_MUL_EN
        if (sel == 4'd15) sel = 4'd4;
`endif
        c = (sel == 4'd5) ? int'(cin) : 0;
        case (sel)
            4'd0: o = a;
            4'd1: o = b;
            4'd2: o = ~a;
            4'd3: o = ~b;
            4'd4, 4'd5: begin
                u = int'(a) + int'(b) + c;
                r = sa + sb + c;
                o = u[15:0]; cy = u[16]; v = r > 32767 || r < -32768;
            end
            4'd6: o = a | b;
            4'd7: o = a & b;
            4'd8: o = '0;
            4'd9: begin o = 16'd1; cy = m_cy; end
            4'd10: begin o = '1; cy = m_cy; end
            4'd11: begin o = m_out; cy = 1'b0; end
            4'd12: begin o = m_out; cy = 1'b1; end
            4'd13: begin
                u = int'(a) - int'(b);
                r = sa - sb;
                o = u[15:0]; cy = a < b; v = r > 32767 || r < -32768;
            end
            4'd14: begin
                if (k == 0) begin o = a; cy = m_cy; end
                else begin x = {16'h0, a} << k; o = x[15:0]; cy = x[16]; lat = k; end
            end
            default: begin
                x = 32'(a) * 32'(b);
                o = x[15:0]; hi = x[31:16]; cy = hi != 0; lat = W;
            end
        endcase
    endtask

    task automatic run(input logic [3:0] sel, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input bit poke);
        logic [W-1:0] eo, eh;
        logic ec, ev;
        int lat, n;
        model(sel, a, b, cin, eo, eh, ec, ev, lat);
        @(negedge System_Clk);
        Start = 1'b1; ALU_Sel = sel; A = a; B = b; Cy_In = cin;
        @(negedge System_Clk);
        Start = 1'b0;
        n = 0;
        while (!Done && n <= lat + 2) begin
            chk("busy", 32'(Busy), 32'd1);
            Start = poke; ALU_Sel = 4'($urandom); A = W'($urandom); B = W'($urandom); Cy_In = 1'($urandom);
            @(negedge System_Clk);
            n++;
        end
        Start = 1'b0;
        chk("done", 32'(Done), 32'd1);
        chk("latency", 32'(n), 32'(lat));
        chk("busy_end", 32'(Busy), 32'd0);
        chk("out", 32'(ALU_Out), 32'(eo));
        chk("hi", 32'(ALU_Out_Hi), 32'(eh));
        chk("cy", 32'(CY_Out), 32'(ec));
        chk("z", 32'(Z_Out), 32'(eo == '0));
        chk("n", 32'(N_Out), 32'(eo[W-1]));
        chk("v", 32'(V_Out), 32'(ev));
        m_out = eo;
        m_cy  = ec;
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_out"}, 32'(ALU_Out), 32'd0);
        chk({tag, "_hi"}, 32'(ALU_Out_Hi), 32'd0);
        chk({tag, "_flags"}, 32'({CY_Out, Z_Out, N_Out, V_Out}), 32'd0);
        chk({tag, "_busy"}, 32'(Busy), 32'd0);
        chk({tag, "_done"}, 32'(Done), 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge System_Clk);
        Reset = 1'b0;
        chk_cleared("reset");
        run(4'h4, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        run(4'hD, 16'h0003, 16'h0005, 1'b0, 1'b0);
        run(4'hD, 16'h7FFF, 16'hFFFF, 1'b0, 1'b0);
        run(4'hE, 16'h8001, 16'h0004, 1'b0, 1'b1);
        run(4'hE, 16'h8001, 16'h0000, 1'b0, 1'b0);
        run(4'hF, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
        run(4'h4, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        run(4'h9, 16'h1234, 16'h5678, 1'b0, 1'b0);
        run(4'hB, 16'h1234, 16'h5678, 1'b0, 1'b0);
        run(4'hC, 16'h0000, 16'h0000, 1'b0, 1'b0);
        run(4'h5, 16'h7FFF, 16'h0000, 1'b1, 1'b0);
        // abort a long operation with reset at edge 5
        @(negedge System_Clk);
`ifdef ALU_ITER_MUL_EN
        Start = 1'b1; ALU_Sel = 4'hF; A = 16'h1234; B = 16'h00FF;
`else
        Start = 1'b1; ALU_Sel = 4'hE; A = 16'h1234; B = 16'h000F;
`endif
        @(negedge System_Clk);
        Start = 1'b0;
        repeat (4) @(negedge System_Clk);
        Reset = 1'b1;
        @(negedge System_Clk);
        Reset = 1'b0;
        chk_cleared("abort");
        repeat (12) @(negedge System_Clk);
        chk("abort_no_done", 32'({Done, Busy}), 32'd0);
        m_out = '0;
        m_cy  = 1'b0;
        run(4'h7, 16'hF0F0, 16'h3C3C, 1'b0, 1'b0);
        for (int i = 0; i < 60; i++)
            run(4'($urandom), W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule

// File: doc/alu_iter.md
# alu_iter

Parametrised, handshake-driven successor to the datapath ALU. Keeps the 4-bit operation encoding for codes 0000–1100, adds subtraction, and adds two multi-cycle operations, a barrel-free iterative shift and a shift-add multiply. Results and flags are registered and qualified by a Start/Busy/Done handshake. It sits between the operand buses and the accumulator/flag registers under control of the instruction sequencer.

## Interface
- WIDTH, 16, operand/result width; ≥4, power of two
- CNT_W, $clog2(WIDTH), shift-count / iteration-counter width (derived, not overridden)
- System_Clk  in  1  system clock, all state on rising edge
- Reset  in  1  synchronous, active-high; one clock, one synchronous active-high reset
- Start  in  1  request; sampled only in IDLE
- ALU_Sel  in  4  operation code, latched with Start
- A, B  in  WIDTH  operands, latched with Start
- Cy_In  in  1  carry in for 0101, latched with Start
- Busy  out  1  high while a multi-cycle op runs
- Done  out  1  one-cycle pulse: ALU_Out/flags updated this cycle
- ALU_Out  out  WIDTH  result, low half for MUL
- ALU_Out_Hi  out  WIDTH  MUL high half; 0 otherwise
- CY_Out, Z_Out, N_Out, V_Out  out  1 each  carry/borrow, zero, negative, signed overflow

## Operation
- Codes 0000–1100: A, B, ~A, ~B, A+B, A+B+Cy_In, A|B, A&B, 0, 1, all-ones, clear carry, set carry.
- 1101: A−B; CY_Out = borrow (1 iff A<B unsigned); V_Out = signed overflow.
- 1110: SHL A by B[CNT_W-1:0], one position per cycle; CY_Out = last bit shifted out; count 0 behaves as single-cycle, ALU_Out=A, CY_Out held.
- 1111: unsigned A×B, shift-add, one partial product per cycle; {ALU_Out_Hi,ALU_Out} = product; CY_Out = (ALU_Out_Hi≠0).
- Carry rules: 0100/0101 carry = bit WIDTH of sum; 0000–0011, 0110, 0111, 1000 clear CY_Out; 1001, 1010 hold CY_Out; 1011/1100 hold ALU_Out, write CY_Out only.
- V_Out: sign overflow for 0100/0101/1101, else 0. Z_Out = (ALU_Out==0), N_Out = ALU_Out[WIDTH-1], recomputed on every Done, including 1011/1100.
- ALU_Out_Hi cleared on every non-MUL completion.
- Outputs hold between Done pulses.
- FSM: IDLE, SHIFT, MUL.
  - IDLE + Start + single-cycle op → results written, Done=1, stay IDLE.
  - IDLE + Start + 1110 with count k≥1 → SHIFT.
  - IDLE + Start + 1111 → MUL.
  - SHIFT/MUL → IDLE when the iteration counter expires.

## Timing
- Reset: all outputs 0, state IDLE, internal operand/counter registers 0. Reset mid-operation aborts with no Done.
- Single-cycle op: Start sampled at edge 0; results and Done visible after edge 0.
- Shift k≥1: Busy=1 after edge 0; one shift per edge 1..k; results, Done=1, Busy=0 after edge k.
- MUL: Busy after edge 0; results, Done, Busy=0 after edge WIDTH.
- While Busy: Start, ALU_Sel, A, B, Cy_In ignored; no queuing. Start in the Done cycle is accepted (IDLE).
- Unknown codes: none exist; all 16 codes defined.

## Configuration
- ALU_ITER_MUL_EN defined: 1111 is the multiply described above.
- Not defined: no multiplier hardware; 1111 executes single-cycle A+B (carry/V as 0100); ALU_Out_Hi tied 0; FSM has no MUL state.

## Structure
- Package alu_iter_pkg holds the 4-bit opcode constants (OP_PASS_A … OP_MUL) and the FSM state typedef.
- One sub-module, alu_iter_mul: shift-add multiplier datapath with its own iteration counter, start/done handshake to the parent. Compiled only under ALU_ITER_MUL_EN.
- Shift and single-cycle logic stay in alu_iter.

## Test plan
- WIDTH=16, A=FFFF, B=0001, ALU_Sel=0100, Start → after edge 0: ALU_Out=0000, CY=1, Z=1, V=0, Done pulse.
- A=0003, B=0005, 1101 → ALU_Out=FFFE, CY(borrow)=1, N=1; then A=7FFF, B=FFFF, 1101 → 8000, V=1.
- A=8001, B=0004, 1110 → Busy for 4 edges, ALU_Out=0010, CY=0. Start pulses during Busy are ignored. Also B=0 → one-cycle, ALU_Out=8001.
- With ALU_ITER_MUL_EN: A=FFFF, B=FFFF, 1111 → Done after edge 16; Hi=FFFE, Out=0001, CY=1. Without the macro: Out=FFFE, CY=1, Hi=0, one cycle.
- CY=1 from previous op; 1001 → Out=0001, CY stays 1; 1011 → Out held at 0001, CY=0, Z=0, Done pulse.
- Reset asserted at edge 5 of a MUL → next cycle all outputs 0, Busy=0, no Done; immediate new Start completes normally.
